// File: rtl/alu_exec_if.sv
// Command/result FIFO bus between alu_exec_engine and its two FIFOs.
// master = engine side (pops commands, pushes results); slave = FIFO side.
interface alu_exec_if #(
    parameter int DATA_SIZE      = 16,
    parameter int OPERATION_SIZE = 3,
    parameter int ID_SIZE        = 4,
    parameter int FIFO_IN_WIDTH  = 2*DATA_SIZE+OPERATION_SIZE+ID_SIZE,
    parameter int FIFO_OUT_WIDTH = 2*DATA_SIZE+1+ID_SIZE
);
    logic [FIFO_IN_WIDTH-1:0]  fifo_in_data;
    logic                      empty_in;
    logic                      r_en_in;
    logic                      full_out;
    logic                      w_en_out;
    logic [FIFO_OUT_WIDTH-1:0] alu_data_out;

    modport master (
        input  fifo_in_data, empty_in, full_out,
        output r_en_in, w_en_out, alu_data_out
    );

    modport slave (
        output fifo_in_data, empty_in, full_out,
        input  r_en_in, w_en_out, alu_data_out
    );
endinterface

// File: rtl/alu_exec_engine.sv
// Single-command ALU: pops {id,op,data1,data0}, executes, pushes {id,err,result}.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiplier for opcode 7.
module alu_exec_engine #(
    parameter int DATA_SIZE      = 16,
    parameter int OPERATION_SIZE = 3,
    parameter int ID_SIZE        = 4,
    parameter int FIFO_IN_WIDTH  = 2*DATA_SIZE+OPERATION_SIZE+ID_SIZE,
    parameter int FIFO_OUT_WIDTH = 2*DATA_SIZE+1+ID_SIZE
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.master bus,
    output logic       busy
);
    localparam int RES_W = 2*DATA_SIZE;

    localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(0);
    localparam logic [OPERATION_SIZE-1:0] OP_SUB = OPERATION_SIZE'(1);
    localparam logic [OPERATION_SIZE-1:0] OP_AND = OPERATION_SIZE'(2);
    localparam logic [OPERATION_SIZE-1:0] OP_OR  = OPERATION_SIZE'(3);
    localparam logic [OPERATION_SIZE-1:0] OP_XOR = OPERATION_SIZE'(4);
    localparam logic [OPERATION_SIZE-1:0] OP_SHL = OPERATION_SIZE'(5);
    localparam logic [OPERATION_SIZE-1:0] OP_SHR = OPERATION_SIZE'(6);
    localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(7);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [FIFO_IN_WIDTH-1:0]  cmd_s;
    logic [DATA_SIZE-1:0]      cmd_data0_s;
    logic [DATA_SIZE-1:0]      cmd_data1_s;
    logic [OPERATION_SIZE-1:0] cmd_op_s;
    logic [ID_SIZE-1:0]        cmd_id_s;

    logic [ID_SIZE-1:0]        id_r;
    logic [OPERATION_SIZE-1:0] op_r;
    logic [DATA_SIZE-1:0]      data0_r;
    logic [DATA_SIZE-1:0]      data1_r;
    logic [FIFO_OUT_WIDTH-1:0] out_r;
    logic                      r_en_r;
    logic                      busy_r;

    logic [DATA_SIZE:0]        add_s;
    logic [DATA_SIZE:0]        sub_s;
    logic [RES_W-1:0]          alu_res_s;
    logic                      alu_err_s;
    logic                      exec_done_s;

    assign cmd_s       = bus.fifo_in_data;
    assign cmd_data0_s = cmd_s[DATA_SIZE-1:0];
    assign cmd_data1_s = cmd_s[2*DATA_SIZE-1:DATA_SIZE];
    assign cmd_op_s    = cmd_s[2*DATA_SIZE+OPERATION_SIZE-1:2*DATA_SIZE];
    assign cmd_id_s    = cmd_s[2*DATA_SIZE+OPERATION_SIZE+ID_SIZE-1:2*DATA_SIZE+OPERATION_SIZE];

    // Extra MSB carries the carry-out of ADD and the borrow of SUB.
    assign add_s = {1'b0, data0_r} + {1'b0, data1_r};
    assign sub_s = {1'b0, data0_r} - {1'b0, data1_r};

`ifdef ALU_EXEC_MUL_EN
    localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_SIZE-1);

    logic [RES_W-1:0]     mul_acc_r;
    logic [RES_W-1:0]     mul_mcand_r;
    logic [DATA_SIZE-1:0] mul_mplier_r;
    logic [CNT_W-1:0]     mul_cnt_r;
    logic [RES_W-1:0]     mul_sum_s;

    // One multiplier bit per EXEC cycle; the last partial sum is the product.
    assign mul_sum_s = mul_acc_r + (mul_mplier_r[0] ? mul_mcand_r : {RES_W{1'b0}});

    // Shift-add multiplier datapath, loaded in LATCH straight from the FIFO word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_acc_r    <= {RES_W{1'b0}};
            mul_mcand_r  <= {RES_W{1'b0}};
            mul_mplier_r <= {DATA_SIZE{1'b0}};
            mul_cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == LATCH) begin
            mul_acc_r    <= {RES_W{1'b0}};
            mul_mcand_r  <= {{DATA_SIZE{1'b0}}, cmd_data0_s};
            mul_mplier_r <= cmd_data1_s;
            mul_cnt_r    <= {CNT_W{1'b0}};
        end else if ((state_r == EXEC) && (op_r == OP_MUL)) begin
            mul_acc_r    <= mul_sum_s;
            mul_mcand_r  <= {mul_mcand_r[RES_W-2:0], 1'b0};
            mul_mplier_r <= {1'b0, mul_mplier_r[DATA_SIZE-1:1]};
            mul_cnt_r    <= mul_cnt_r + CNT_W'(1);
        end
    end
`endif

    // Result/err selection and EXEC completion for the latched opcode.
    always_comb begin
        alu_res_s   = {RES_W{1'b0}};
        alu_err_s   = 1'b0;
        exec_done_s = 1'b1;
        case (op_r)
            OP_ADD:  alu_res_s = {{(DATA_SIZE-1){1'b0}}, add_s};
            OP_SUB:  alu_res_s = {{(DATA_SIZE-1){1'b0}}, sub_s};
            OP_AND:  alu_res_s = {{DATA_SIZE{1'b0}}, data0_r & data1_r};
            OP_OR:   alu_res_s = {{DATA_SIZE{1'b0}}, data0_r | data1_r};
            OP_XOR:  alu_res_s = {{DATA_SIZE{1'b0}}, data0_r ^ data1_r};
            OP_SHL:  alu_res_s = {{DATA_SIZE{1'b0}}, data0_r << data1_r[3:0]};
            OP_SHR:  alu_res_s = {{DATA_SIZE{1'b0}}, data0_r >> data1_r[3:0]};
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: begin
                alu_res_s   = mul_sum_s;
                exec_done_s = (mul_cnt_r == MUL_LAST);
            end
`else
            OP_MUL:  alu_err_s = 1'b1;
`endif
            default: alu_err_s = 1'b1;
        endcase
    end

    // Next-state logic; empty_in only matters in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!bus.empty_in) state_s = READ;
                else               state_s = IDLE;
            end
            READ:  state_s = LATCH;
            LATCH: state_s = EXEC;
            EXEC: begin
                if (exec_done_s) state_s = WRITE;
                else             state_s = EXEC;
            end
            WRITE: begin
                if (!bus.full_out) state_s = IDLE;
                else               state_s = WRITE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand latch, registered strobes and the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            r_en_r  <= 1'b0;
            busy_r  <= 1'b0;
            id_r    <= {ID_SIZE{1'b0}};
            op_r    <= {OPERATION_SIZE{1'b0}};
            data0_r <= {DATA_SIZE{1'b0}};
            data1_r <= {DATA_SIZE{1'b0}};
            out_r   <= {FIFO_OUT_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            r_en_r  <= (state_s == READ);
            busy_r  <= (state_s != IDLE);
            if (state_r == LATCH) begin
                id_r    <= cmd_id_s;
                op_r    <= cmd_op_s;
                data0_r <= cmd_data0_s;
                data1_r <= cmd_data1_s;
            end
            if ((state_r == EXEC) && exec_done_s) begin
                out_r <= FIFO_OUT_WIDTH'({id_r, alu_err_s, alu_res_s});
            end
        end
    end

    // Push is gated by full_out and rst_n so a stalled or aborted WRITE never lands.
    assign bus.w_en_out     = rst_n & (state_r == WRITE) & ~bus.full_out;
    assign bus.r_en_in      = r_en_r;
    assign bus.alu_data_out = out_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_alu_exec_engine.sv
// Self-checking bench for alu_exec_engine: FIFO models on both sides plus an
// arithmetic reference model; honours ALU_EXEC_MUL_EN.
module tb_alu_exec_engine;
    localparam int DS = 16;
    localparam int OS = 3;
    localparam int IS = 4;
    localparam int IW = 2*DS+OS+IS;
    localparam int OW = 2*DS+1+IS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    alu_exec_if #(.DATA_SIZE(DS), .OPERATION_SIZE(OS), .ID_SIZE(IS),
                  .FIFO_IN_WIDTH(IW), .FIFO_OUT_WIDTH(OW)) bus ();

    alu_exec_engine #(.DATA_SIZE(DS), .OPERATION_SIZE(OS), .ID_SIZE(IS),
                      .FIFO_IN_WIDTH(IW), .FIFO_OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_cnt = 0;
    int overlap_cnt = 0;
    int underflow_cnt = 0;
    int last_push_cyc = 0;
    logic s_ren, s_wen, s_busy;
    logic [OW-1:0] s_data;
    logic [IW-1:0] cmd_q[$];
    logic [OW-1:0] got_q[$];
    logic [OW-1:0] exp_q[$];

    function automatic logic [IW-1:0] make_cmd(input logic [3:0] id, input logic [2:0] op,
                                               input logic [15:0] d0, input logic [15:0] d1);
        return {id, op, d1, d0};
    endfunction

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic logic [OW-1:0] ref_model(input logic [IW-1:0] c);
        longint unsigned a, b, r;
        logic err;
        logic [3:0] sh;
        a = longint'(c[15:0]);
        b = longint'(c[31:16]);
        sh = c[19:16];
        err = 1'b0;
        case (c[34:32])
            3'd0: r = a + b;
            3'd1: r = (a >= b) ? (a - b) : (a + 65536 - b + 65536);
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (a << sh) % 65536;
            3'd6: r = a >> sh;
`ifdef ALU_EXEC_MUL_EN
            3'd7: r = a * b;
`else
            3'd7: begin r = 0; err = 1'b1; end
`endif
            default: r = 0;
        endcase
        return {c[38:35], err, r[31:0]};
    endfunction

    // One clock: sample outputs at negedge, then play both FIFOs after posedge.
    task automatic tick();
        @(negedge clk);
        s_ren  = bus.r_en_in;
        s_wen  = bus.w_en_out;
        s_busy = busy;
        s_data = bus.alu_data_out;
        if (s_ren === 1'b1 && s_wen === 1'b1) overlap_cnt++;
        if (s_ren === 1'b1) ren_cnt++;
        if (s_wen === 1'b1) begin
            got_q.push_back(s_data);
            last_push_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_ren === 1'b1) begin
            if (cmd_q.size() > 0) bus.fifo_in_data = cmd_q.pop_front();
            else underflow_cnt++;
        end
        bus.empty_in = (cmd_q.size() == 0);
    endtask

    task automatic enqueue(input logic [IW-1:0] c);
        cmd_q.push_back(c);
        bus.empty_in = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [OW-1:0] exp;
        rst_n = 1'b0;
        bus.empty_in = 1'b1;
        bus.full_out = 1'b0;
        bus.fifo_in_data = '0;
        repeat (3) tick();
        enqueue(make_cmd(4'd4, 3'd0, 16'd5, 16'd6));
        repeat (3) tick();
        checks++; if (s_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", s_ren); end
        checks++; if (s_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", s_wen); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", s_busy); end
        checks++; if (s_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", s_data); end
        rst_n = 1'b1;
        got_q.delete();
        exp = {4'd4, 1'b0, 32'd11};
        n = 0;
        while (got_q.size() == 0 && n < 50) begin tick(); n++; end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL post_reset_push: got %0d pushes expected 1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== exp) begin errors++; $display("FAIL post_reset_data: got %h expected %h", got_q[0], exp); end
        end
        repeat (2) tick();
    endtask

    task automatic test_directed();
        logic [IW-1:0] d_cmd[6];
        logic [OW-1:0] d_exp[6];
        int d_lat[6];
        int start, n;
        d_cmd[0] = make_cmd(4'd3, 3'd0, 16'hFFFF, 16'h0002); d_exp[0] = {4'd3, 1'b0, 32'h0001_0001}; d_lat[0] = 4;
        d_cmd[1] = make_cmd(4'd5, 3'd1, 16'h0001, 16'h0002); d_exp[1] = {4'd5, 1'b0, 32'h0001_FFFF}; d_lat[1] = 4;
        d_cmd[2] = make_cmd(4'd1, 3'd5, 16'h8001, 16'h0003); d_exp[2] = {4'd1, 1'b0, 32'h0000_0008}; d_lat[2] = 4;
        d_cmd[3] = make_cmd(4'd2, 3'd6, 16'h8000, 16'h00F3); d_exp[3] = {4'd2, 1'b0, 32'h0000_1000}; d_lat[3] = 4;
        d_cmd[4] = make_cmd(4'd6, 3'd4, 16'hA5A5, 16'hFFFF); d_exp[4] = {4'd6, 1'b0, 32'h0000_5A5A}; d_lat[4] = 4;
`ifdef ALU_EXEC_MUL_EN
        d_cmd[5] = make_cmd(4'd9, 3'd7, 16'h1234, 16'h0100); d_exp[5] = {4'd9, 1'b0, 32'h0012_3400}; d_lat[5] = 19;
`else
        d_cmd[5] = make_cmd(4'd9, 3'd7, 16'h1234, 16'h0100); d_exp[5] = {4'd9, 1'b1, 32'h0000_0000}; d_lat[5] = 4;
`endif
        for (int i = 0; i < 6; i++) begin
            got_q.delete();
            start = cyc;
            enqueue(d_cmd[i]);
            n = 0;
            while (got_q.size() == 0 && n < 60) begin tick(); n++; end
            repeat (3) tick();
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL directed_push[%0d]: got %0d pushes expected 1", i, got_q.size());
            end else begin
                checks++;
                if (got_q[0] !== d_exp[i]) begin errors++; $display("FAIL directed_data[%0d]: got %h expected %h", i, got_q[0], d_exp[i]); end
                checks++;
                if (last_push_cyc - start != d_lat[i]) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, last_push_cyc - start, d_lat[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] exp;
        int start, n;
        got_q.delete();
        bus.full_out = 1'b1;
        exp = {4'd7, 1'b0, 32'h0000_3030};
        start = cyc;
        enqueue(make_cmd(4'd7, 3'd2, 16'hF0F0, 16'h3C3C));
        while (cyc < start + 4) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (s_wen !== 1'b0) begin errors++; $display("FAIL bp_wen[%0d]: got %b expected 0", i, s_wen); end
            checks++;
            if (s_data !== exp) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, s_data, exp); end
        end
        bus.full_out = 1'b0;
        n = 0;
        while (got_q.size() == 0 && n < 20) begin tick(); n++; end
        repeat (3) tick();
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL bp_push_count: got %0d expected 1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== exp) begin errors++; $display("FAIL bp_push_data: got %h expected %h", got_q[0], exp); end
        end
    endtask

    task automatic test_random();
        logic [IW-1:0] c;
        logic [15:0] a, b;
        int n, ren0;
        got_q.delete();
        exp_q.delete();
        ren0 = ren_cnt;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFF;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
            c = make_cmd(4'($urandom), 3'($urandom), a, b);
            exp_q.push_back(ref_model(c));
            enqueue(c);
        end
        n = 0;
        while (got_q.size() < 30 && n < 2000) begin
            bus.full_out = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        bus.full_out = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_q.size() != 30) begin errors++; $display("FAIL rand_count: got %0d expected 30", got_q.size()); end
        else begin
            for (int i = 0; i < 30; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (ren_cnt - ren0 != 30) begin errors++; $display("FAIL rand_pops: got %0d expected 30", ren_cnt - ren0); end
    endtask

    task automatic test_reset_mid_exec();
        logic [IW-1:0] c;
        int start, n, ren0;
        got_q.delete();
        exp_q.delete();
        ren0 = ren_cnt;
        start = cyc;
        enqueue(make_cmd(4'd9, 3'd7, 16'h1234, 16'h0100));
        while (cyc < start + 3) tick();
`ifdef ALU_EXEC_MUL_EN
        repeat (5) tick();
`endif
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", s_busy); end
        checks++; if (s_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", s_data); end
        checks++; if (s_ren !== 1'b0 || s_wen !== 1'b0) begin errors++; $display("FAIL mid_rst_strobes: got ren=%b wen=%b expected 0", s_ren, s_wen); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c = make_cmd(4'(i + 10), 3'(i), 16'(16'h1111 * (i + 1)), 16'h0F0F);
            exp_q.push_back(ref_model(c));
            enqueue(c);
        end
        n = 0;
        while (got_q.size() < 3 && n < 200) begin tick(); n++; end
        repeat (3) tick();
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL mid_rst_count: got %0d expected 3", got_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_rst_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (ren_cnt - ren0 != 4) begin errors++; $display("FAIL mid_rst_pops: got %0d expected 4", ren_cnt - ren0); end
    endtask

    task automatic test_protocol();
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
        checks++;
        if (underflow_cnt != 0) begin errors++; $display("FAIL pop_empty: got %0d expected 0", underflow_cnt); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_exec();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/alu_exec_engine.md
ALU_EXEC_ENGINE -- requirements
Module: alu_exec_engine

Interface
- REQ-001 The block SHALL have parameter DATA_SIZE, default 16: the operand width.
- REQ-002 The block SHALL have parameter OPERATION_SIZE, default 3: the opcode width.
- REQ-003 The block SHALL have parameter ID_SIZE, default 4: the transaction ID width.
- REQ-004 The block SHALL have parameter FIFO_IN_WIDTH, default 2*DATA_SIZE+OPERATION_SIZE+ID_SIZE.
- REQ-005 The block SHALL have parameter FIFO_OUT_WIDTH, default 2*DATA_SIZE+1+ID_SIZE.
- REQ-006 Port clk, input, 1 bit: the single clock, rising-edge.
- REQ-007 Port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-008 Port fifo_in_data, input, FIFO_IN_WIDTH bits, laid out as {id, op, data1, data0}, with data0 in the LSBs.
- REQ-009 Port empty_in, input, 1 bit: the command FIFO is empty.
- REQ-010 Port r_en_in, output, 1 bit: the command FIFO pop strobe.
- REQ-011 Port full_out, input, 1 bit: the result FIFO is full.
- REQ-012 Port w_en_out, output, 1 bit: the result FIFO push strobe.
- REQ-013 Port alu_data_out, output, FIFO_OUT_WIDTH bits, laid out as {id, err, result[2*DATA_SIZE-1:0]}.
- REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
- REQ-015 The FSM SHALL have the states IDLE, READ, LATCH, EXEC and WRITE.
- REQ-016 IDLE SHALL go to READ when empty_in=0 and stay in IDLE otherwise.
- REQ-017 READ SHALL drive r_en_in=1 for exactly one cycle and always go to LATCH.
- REQ-018 LATCH SHALL register id, op, data0 and data1 from fifo_in_data (read data is valid one cycle after r_en_in) and go to EXEC.
- REQ-019 EXEC SHALL compute the result and go to WRITE; it takes one cycle for every op except MUL.
- REQ-020 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by data1[3:0], 6 SHR (logical) by data1[3:0], 7 MUL.
- REQ-021 ADD SHALL place the carry-out in result[DATA_SIZE] and zero-extend the remaining upper bits.
- REQ-022 SUB SHALL compute data0-data1 modulo 2^DATA_SIZE, set result[DATA_SIZE]=1 on borrow, and zero the remaining upper bits.
- REQ-023 The logic ops and shifts SHALL produce a DATA_SIZE-bit value with the upper DATA_SIZE bits zero.
- REQ-024 MUL SHALL be an iterative unsigned shift-add over exactly DATA_SIZE EXEC cycles, producing the full 2*DATA_SIZE-bit product.
- REQ-025 err SHALL be 0 for every legal op.
- REQ-026 WRITE SHALL drive w_en_out=1 only while full_out=0, then go to IDLE in the following cycle.
- REQ-027 While full_out=1, WRITE SHALL hold with w_en_out=0 and alu_data_out stable.
- REQ-028 alu_data_out SHALL be registered and SHALL change only on EXEC completion.
- REQ-029 r_en_in and w_en_out SHALL never be high in the same cycle, and each SHALL be a single-cycle pulse per transaction.
- REQ-030 Latency for a single-cycle op SHALL be: empty_in sampled low at cycle N, r_en_in at N+1, w_en_out at N+4 when full_out=0.
- REQ-031 empty_in SHALL be ignored outside IDLE.
- REQ-032 An empty_in glitch during READ SHALL have no effect, because the pop has already been committed.

Reset
- REQ-033 On rst_n=0 at a clock edge, the block SHALL go to IDLE and clear r_en_in, w_en_out, busy, alu_data_out and all operand and multiply registers to 0.
- REQ-034 A reset in any state, including mid-MUL or a stalled WRITE, SHALL abort the transaction with no push, and the popped entry is lost.
- REQ-035 The first pop after rst_n rises SHALL occur no earlier than the second clock edge after release.

Configuration
- REQ-036 The macro ALU_EXEC_MUL_EN SHALL control whether the multiplier is built.
- REQ-037 With ALU_EXEC_MUL_EN defined, op 7 SHALL be MUL as described in REQ-024.
- REQ-038 Without ALU_EXEC_MUL_EN, no multiplier logic SHALL exist.
- REQ-039 Without ALU_EXEC_MUL_EN, op 7 SHALL be illegal: a 1-cycle EXEC with result=0 and err=1, still pushed to the result FIFO with its id.

Verification
- REQ-040 ADD test: id=3, op=0, data0=0xFFFF, data1=0x0002 -> one push with alu_data_out={3,0,0x0001_0001}, w_en_out 4 cycles after empty_in falls.
- REQ-041 SUB test: op=1, data0=0x0001, data1=0x0002 -> result=0x0001_FFFF, err=0.
- REQ-042 MUL test with the macro defined: op=7, data0=0x1234, data1=0x0100 -> result=0x0012_3400, w_en_out 19 cycles after empty_in falls.
- REQ-043 MUL test without the macro: op=7, id=9 -> {9,1,0}, single-cycle EXEC.
- REQ-044 Backpressure test: full_out=1 for 10 cycles during WRITE -> w_en_out stays 0 and data is stable; after full_out falls, exactly one push occurs.
- REQ-045 Reset test: rst_n=0 in EXEC of a MUL -> next cycle IDLE, all outputs 0, no push; three queued entries afterwards -> three pushes in order, each with r_en_in pulsed once.
